velocity_solver: RTL and testbench
==================================

VELOCITY_SOLVER -- requirements
Module: velocity_solver

Interface
REQ-001 SHALL have parameter TENSOR_W, default 24, signed tensor element width.
REQ-002 SHALL have parameter OUT_INT_W, default 6, integer bits of each velocity output, sign bit included.
REQ-003 SHALL have parameter OUT_FRAC_W, default 6, fraction bits of each velocity output; OUT_W = OUT_INT_W + OUT_FRAC_W.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: tensor set and k valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts input.
REQ-008 SHALL have port tensors, input, 6*TENSOR_W bits, signed {xx,xy,xt,yy,yt,tt} with xx in the MSBs; tt unused.
REQ-009 SHALL have port k, input, TENSOR_W bits: regularisation term added to xx and yy.
REQ-010 SHALL have port det_min, input, PROD_W bits, unsigned: determinant threshold, see Configuration.
REQ-011 SHALL have ports vx and vy, output, OUT_W bits each, signed fixed point.
REQ-012 SHALL have ports sat_x and sat_y, output, 1 bit each: the corresponding output was saturated.
REQ-013 SHALL have port det_err, output, 1 bit: determinant rejected; vx and vy forced to 0.
REQ-014 SHALL have port out_valid, output, 1 bit, and port out_ready, input, 1 bit.

Function
REQ-015 SHALL compute xa=xx+k and ya=yy+k at TENSOR_W+1 bits; all products and differences at PROD_W = 2*TENSOR_W+3 bits with no wrap.
REQ-016 SHALL compute the Cramer-rule terms: det = xa*ya - xy*xy; nx = xt*ya - yt*xy; ny = yt*xa - xt*xy.
REQ-017 SHALL produce vx = nx*2^OUT_FRAC_W/det and vy = ny*2^OUT_FRAC_W/det, truncated toward zero.
REQ-018 SHALL saturate each result to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and assert the matching sat_x or sat_y when clipping occurs.
REQ-019 SHALL, when det == 0, output vx=vy=0 with det_err=1 and sat_x=sat_y=0, in the same latency as normal operation.
REQ-020 SHALL implement the FSM IDLE -> MUL -> DIFF -> DIV -> SAT -> HOLD -> IDLE.
REQ-021 SHALL assert in_ready only in IDLE and capture inputs on the edge where in_valid and in_ready are both 1.
REQ-022 SHALL keep DIV for exactly DIV_ITERS = PROD_W + OUT_FRAC_W cycles, computing both quotients in parallel.
REQ-023 SHALL assert out_valid on edge LATENCY = DIV_ITERS + 4 after the capture edge.
REQ-024 SHALL hold vx, vy, sat_x, sat_y and det_err stable while out_valid=1 and out_ready=0.
REQ-025 SHALL, in HOLD with out_ready=1, deassert out_valid on the next edge and return to IDLE; the next input is accepted no earlier than the edge after that.
REQ-026 SHALL sample in_valid only in IDLE; tensors may change freely in all other states.

Reset
REQ-027 SHALL, while rst_n=0, force FSM=IDLE, in_ready=0, out_valid=0, vx=vy=0 and sat_x=sat_y=det_err=0; in_ready rises on the first edge after release.
REQ-028 SHALL, when reset is asserted mid-computation, abort the computation and never emit its result.

Configuration
REQ-029 SHALL, with VELOCITY_SOLVER_DET_THRESH_EN defined, treat |det| < det_min as a rejected determinant (REQ-019 behaviour).
REQ-030 SHALL, without VELOCITY_SOLVER_DET_THRESH_EN, ignore det_min and reject only det == 0; the port exists in both builds.

Structure
REQ-031 SHALL place PROD_W, DIV_ITERS, LATENCY and the FSM state enum in package velocity_solver_pkg.
REQ-032 SHALL use one sub-module, frac_divider: signed-magnitude restoring divider with start/done, DIV_ITERS cycles, instanced twice.

Verification (TENSOR_W=24, OUT_INT_W=6, OUT_FRAC_W=6)
REQ-033 SHALL cover: xx=yy=4, xy=0, xt=8, yt=-4, k=0 -> vx=0x080, vy=0xFC0, flags 0, out_valid at LATENCY.
REQ-034 SHALL cover: xx=yy=3, xy=0, xt=1 then xt=-1, yt=0 -> vx=0x015 then 0xFEB (truncation toward zero).
REQ-035 SHALL cover: xx=yy=1, xy=0, xt=100, yt=-100 -> vx=0x7FF with sat_x=1, vy=0x800 with sat_y=1.
REQ-036 SHALL cover: xx=yy=xy=0 with k=0 -> det_err=1, vx=vy=0; the same tensors with k=2, xt=4, yt=2 -> vx=0x080, vy=0x040.
REQ-037 SHALL cover: out_ready held 0 for 10 cycles -> outputs stable, in_ready=0; then handshake followed by a new accept.
REQ-038 SHALL cover: rst_n pulsed low mid-DIV -> no out_valid; the next transaction gives correct results. With the macro: det=16, det_min=20 -> det_err=1.

Source files
------------

// File: rtl/velocity_solver_pkg.sv
// Shared constants, FSM state encoding and width helpers for the velocity solver.
package velocity_solver_pkg;

  localparam int DEF_TENSOR_W   = 24;
  localparam int DEF_OUT_FRAC_W = 6;
  localparam int PROD_W         = 2 * DEF_TENSOR_W + 3;
  localparam int DIV_ITERS      = PROD_W + DEF_OUT_FRAC_W;
  localparam int LATENCY        = DIV_ITERS + 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIFF = 3'd2,
    ST_DIV  = 3'd3,
    ST_SAT  = 3'd4,
    ST_HOLD = 3'd5
  } state_e;

  function automatic int prod_w(input int tensor_w);
    return 2 * tensor_w + 3;
  endfunction

  function automatic int div_iters(input int tensor_w, input int frac_w);
    return prod_w(tensor_w) + frac_w;
  endfunction

endpackage

// File: rtl/velocity_solver_frac_divider.sv
// Signed-magnitude restoring divider: one quotient bit per cycle, N_W cycles after start.
module frac_divider #(
  parameter int N_W = 57,
  parameter int D_W = 51
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic signed [N_W:0]   dividend,
  input  logic signed [D_W-1:0] divisor,
  output logic               done,
  output logic signed [N_W:0]   quotient
);

  localparam int CW = $clog2(N_W + 1);

  logic [CW-1:0]  cnt;
  logic           busy;
  logic           neg;
  logic [N_W-1:0] quo;
  logic [D_W-1:0] rem;
  logic [D_W-1:0] dvs;
  logic [D_W:0]   shifted;
  logic [D_W:0]   trial;

  // rem < dvs always holds, so the shifted remainder fits in D_W+1 bits
  assign shifted = {rem, quo[N_W-1]};
  assign trial   = shifted - {1'b0, dvs};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy <= 1'b1;
        cnt  <= CW'(N_W);
      end else if (busy) begin
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  // NOTE: datapath registers carry no reset; control (busy/done) qualifies them.
  always_ff @(posedge clk) begin
    if (start) begin
      neg <= dividend[N_W] ^ divisor[D_W-1];
      quo <= dividend[N_W] ? N_W'(-dividend) : N_W'(dividend);
      rem <= '0;
      dvs <= divisor[D_W-1] ? D_W'(-divisor) : D_W'(divisor);
    end else if (busy) begin
      quo <= {quo[N_W-2:0], ~trial[D_W]};
      rem <= trial[D_W] ? shifted[D_W-1:0] : trial[D_W-1:0];
    end
  end

  assign quotient = neg ? -$signed({1'b0, quo}) : $signed({1'b0, quo});

endmodule

// File: rtl/velocity_solver.sv
// Cramer-rule 2x2 velocity solver with fixed-point saturating outputs.
// Optional build macro VELOCITY_SOLVER_DET_THRESH_EN enables the |det| < det_min rejection.
module velocity_solver
  import velocity_solver_pkg::*;
#(
  parameter int TENSOR_W   = 24,
  parameter int OUT_INT_W  = 6,
  parameter int OUT_FRAC_W = 6,
  localparam int OUT_W     = OUT_INT_W + OUT_FRAC_W,
  localparam int PW        = prod_w(TENSOR_W)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [6*TENSOR_W-1:0]   tensors,
  input  logic [TENSOR_W-1:0]     k,
  input  logic [PW-1:0]           det_min,
  output logic signed [OUT_W-1:0] vx,
  output logic signed [OUT_W-1:0] vy,
  output logic                    sat_x,
  output logic                    sat_y,
  output logic                    det_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int DW = div_iters(TENSOR_W, OUT_FRAC_W);
  localparam logic signed [DW:0] Q_MAX = (DW+1)'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [DW:0] Q_MIN = ~Q_MAX;

  logic signed [TENSOR_W-1:0] xx_in, xy_in, xt_in, yy_in, yt_in, k_in;
  logic unused_tt;

  assign xx_in     = tensors[6*TENSOR_W-1 -: TENSOR_W];
  assign xy_in     = tensors[5*TENSOR_W-1 -: TENSOR_W];
  assign xt_in     = tensors[4*TENSOR_W-1 -: TENSOR_W];
  assign yy_in     = tensors[3*TENSOR_W-1 -: TENSOR_W];
  assign yt_in     = tensors[2*TENSOR_W-1 -: TENSOR_W];
  assign k_in      = k;
  assign unused_tt = ^tensors[TENSOR_W-1:0];

  state_e state, nxt;

  logic signed [PW-1:0] xa, ya, xy_q, xt_q, yt_q;
  logic signed [PW-1:0] p_xaya, p_xyxy, p_xtya, p_ytxy, p_ytxa, p_xtxy;
  logic signed [PW-1:0] det_c, nx_c, ny_c;
  logic                 reject_c, reject_q;
  logic signed [DW:0]   dvd_x, dvd_y, q_x, q_y;
  logic                 done_x, done_y, div_start;
  logic [OUT_W:0]       clip_x, clip_y;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: if (in_valid && in_ready) nxt = ST_MUL;
      ST_MUL:  nxt = ST_DIFF;
      ST_DIFF: nxt = ST_DIV;
      ST_DIV:  if (done_x && done_y) nxt = ST_SAT;
      ST_SAT:  nxt = ST_HOLD;
      ST_HOLD: if (out_ready) nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= nxt;
      in_ready  <= (nxt == ST_IDLE);
      out_valid <= (nxt == ST_HOLD);
    end
  end

  always_ff @(posedge clk) begin
    case (state)
      ST_IDLE: if (in_valid && in_ready) begin
        xa   <= PW'(xx_in) + PW'(k_in);
        ya   <= PW'(yy_in) + PW'(k_in);
        xy_q <= PW'(xy_in);
        xt_q <= PW'(xt_in);
        yt_q <= PW'(yt_in);
      end
      ST_MUL: begin
        p_xaya <= xa * ya;
        p_xyxy <= xy_q * xy_q;
        p_xtya <= xt_q * ya;
        p_ytxy <= yt_q * xy_q;
        p_ytxa <= yt_q * xa;
        p_xtxy <= xt_q * xy_q;
      end
      ST_DIFF: reject_q <= reject_c;
      default: ;
    endcase
  end

  assign det_c = p_xaya - p_xyxy;
  assign nx_c  = p_xtya - p_ytxy;
  assign ny_c  = p_ytxa - p_xtxy;

`ifdef VELOCITY_SOLVER_DET_THRESH_EN
  logic [PW-1:0] det_abs;
  assign det_abs  = det_c[PW-1] ? PW'(-det_c) : PW'(det_c);
  assign reject_c = (det_c == '0) || (det_abs < det_min);
`else
  logic unused_det_min;
  assign unused_det_min = ^det_min;
  assign reject_c       = (det_c == '0);
`endif

  // Numerators are pre-scaled by 2^OUT_FRAC_W so the quotient lands in output fixed point
  assign dvd_x     = {nx_c[PW-1], nx_c, {OUT_FRAC_W{1'b0}}};
  assign dvd_y     = {ny_c[PW-1], ny_c, {OUT_FRAC_W{1'b0}}};
  assign div_start = (state == ST_DIFF);

  frac_divider #(.N_W(DW), .D_W(PW)) u_div_x (
    .clk(clk), .rst_n(rst_n), .start(div_start),
    .dividend(dvd_x), .divisor(det_c), .done(done_x), .quotient(q_x)
  );

  frac_divider #(.N_W(DW), .D_W(PW)) u_div_y (
    .clk(clk), .rst_n(rst_n), .start(div_start),
    .dividend(dvd_y), .divisor(det_c), .done(done_y), .quotient(q_y)
  );

  function automatic logic [OUT_W:0] clip(input logic signed [DW:0] q);
    if (q > Q_MAX)      return {1'b1, Q_MAX[OUT_W-1:0]};
    else if (q < Q_MIN) return {1'b1, Q_MIN[OUT_W-1:0]};
    else                return {1'b0, q[OUT_W-1:0]};
  endfunction

  assign clip_x = clip(q_x);
  assign clip_y = clip(q_y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vx      <= '0;
      vy      <= '0;
      sat_x   <= 1'b0;
      sat_y   <= 1'b0;
      det_err <= 1'b0;
    end else if (state == ST_SAT) begin
      if (reject_q) begin
        vx      <= '0;
        vy      <= '0;
        sat_x   <= 1'b0;
        sat_y   <= 1'b0;
        det_err <= 1'b1;
      end else begin
        vx      <= clip_x[OUT_W-1:0];
        vy      <= clip_y[OUT_W-1:0];
        sat_x   <= clip_x[OUT_W];
        sat_y   <= clip_y[OUT_W];
        det_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_velocity_solver.sv
// Scoreboard bench for velocity_solver: driver pushes model results, monitor pops on handshake.
module tb_velocity_solver;
  import velocity_solver_pkg::*;

  localparam int TW = 24;
  localparam int OW = 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [6*TW-1:0]   tensors = '0;
  logic [TW-1:0]     k = '0;
  logic [PROD_W-1:0] det_min = '0;
  logic [OW-1:0]     vx, vy;
  logic              sat_x, sat_y, det_err, out_valid;
  logic              out_ready = 1'b0;

  velocity_solver #(.TENSOR_W(TW), .OUT_INT_W(6), .OUT_FRAC_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .tensors(tensors), .k(k), .det_min(det_min),
    .vx(vx), .vy(vy), .sat_x(sat_x), .sat_y(sat_y), .det_err(det_err),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] vx;
    logic [OW-1:0] vy;
    logic          sx;
    logic          sy;
    logic          de;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   rdy_mode = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference: plain 64-bit arithmetic straight from Cramer's rule
  function automatic void sat_ref(input longint q, output logic [OW-1:0] v, output logic s);
    longint lim_hi = (64'sd1 <<< (OW - 1)) - 1;
    longint lim_lo = -(64'sd1 <<< (OW - 1));
    if (q > lim_hi)      begin v = OW'(lim_hi); s = 1'b1; end
    else if (q < lim_lo) begin v = OW'(lim_lo); s = 1'b1; end
    else                 begin v = OW'(q);      s = 1'b0; end
  endfunction

  function automatic exp_t model(input longint xx, xy, xt, yy, yt, kk, dmin);
    exp_t   e;
    longint xa = xx + kk;
    longint ya = yy + kk;
    longint det = xa * ya - xy * xy;
    longint nx = xt * ya - yt * xy;
    longint ny = yt * xa - xt * xy;
    longint adet = (det < 0) ? -det : det;
    bit     reject = (det == 0);
`ifdef VELOCITY_SOLVER_DET_THRESH_EN
    if (adet < dmin) reject = 1'b1;
`else
    if (adet < 0 || dmin < 0) reject = 1'b1;
`endif
    if (reject) begin
      e.vx = '0; e.vy = '0; e.sx = 1'b0; e.sy = 1'b0; e.de = 1'b1;
    end else begin
      sat_ref((nx * 64) / det, e.vx, e.sx);
      sat_ref((ny * 64) / det, e.vy, e.sy);
      e.de = 1'b0;
    end
    return e;
  endfunction

  function automatic longint rnd_val();
    logic signed [TW-1:0] r;
    case ($urandom_range(0, 2))
      0: return longint'($urandom_range(0, 16)) - 8;
      1: return longint'($urandom_range(0, 4000)) - 2000;
      default: begin r = TW'($urandom); return longint'(r); end
    endcase
  endfunction

  // Called at posedge+1; returns at posedge+1 after the capture edge
  task automatic send(input longint xx, xy, xt, yy, yt, kk, dm);
    int t = 0;
    tensors  = {TW'(xx), TW'(xy), TW'(xt), TW'(yy), TW'(yt), TW'($urandom)};
    k        = TW'(kk);
    det_min  = PROD_W'(dm);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("accept_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(model(xx, xy, xt, yy, yt, kk, dm));
    acc_q.push_back(cyc + 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    tensors  = {$urandom, $urandom, $urandom, $urandom, $urandom};
    k        = TW'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("drain", exp_q.size(), 0);
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_vx", vx, 0);
    check("rst_vy", vy, 0);
    check("rst_flags", {sat_x, sat_y, det_err}, 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: latency on out_valid rise, stability while stalled, scoreboard on handshake
  logic          prev_ov = 1'b0;
  logic          prev_rdy = 1'b0;
  logic [OW-1:0] s_vx, s_vy;
  logic [2:0]    s_flags;
  exp_t          got_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (acc_q.size() == 0) check("unexpected_out_valid", out_valid, 0);
        else check("latency", cyc - acc_q.pop_front(), LATENCY);
      end
      if (out_valid && prev_ov && !prev_rdy) begin
        check("stall_vx", vx, s_vx);
        check("stall_vy", vy, s_vy);
        check("stall_flags", {sat_x, sat_y, det_err}, s_flags);
        check("stall_in_ready", in_ready, 0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_handshake", out_valid, 0);
        end else begin
          got_e = exp_q.pop_front();
          check("vx", vx, got_e.vx);
          check("vy", vy, got_e.vy);
          check("sat_x", sat_x, got_e.sx);
          check("sat_y", sat_y, got_e.sy);
          check("det_err", det_err, got_e.de);
        end
      end
      s_vx     = vx;
      s_vy     = vy;
      s_flags  = {sat_x, sat_y, det_err};
      prev_ov  = out_valid;
      prev_rdy = out_ready;
    end
  end

  initial begin
    int t;
    int seen;
    repeat (3) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    #1;
    check("in_ready_before_edge", in_ready, 0);
    @(negedge clk);
    check("in_ready_after_release", in_ready, 1);
    @(posedge clk);
    #1;

    // Directed cases
    send(4, 0, 8, 4, -4, 0, 0);
    send(3, 0, 1, 3, 0, 0, 0);
    send(3, 0, -1, 3, 0, 0, 0);
    send(1, 0, 100, 1, -100, 0, 0);
    send(0, 0, 8, 0, -4, 0, 0);
    send(0, 0, 4, 0, 2, 2, 0);
    send(4, 0, 8, 4, -4, 0, 20);
    send(4, 0, 8, 4, -4, 0, 16);
    drain();

    // Back-pressure: outputs must hold for 10 stalled cycles
    rdy_mode = 2;
    @(posedge clk);
    #1;
    send(2, 1, 5, 3, -7, 1, 0);
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("stall_out_valid", out_valid, 1);
    repeat (10) @(negedge clk);
    check("stall_still_valid", out_valid, 1);
    rdy_mode = 0;
    @(posedge clk);
    #1;
    send(-5, 2, 300, 7, 11, 0, 0);
    drain();

    // Abort mid-division
    @(posedge clk);
    #1;
    send(4, 0, 8, 4, -4, 0, 0);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    #1;
    check_reset_values();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (LATENCY + 10) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no_result_after_abort", seen, 0);
    @(posedge clk);
    #1;
    send(3, 0, -1, 3, 0, 0, 0);
    drain();

    // Randomised traffic with random back-pressure
    rdy_mode = 1;
    @(posedge clk);
    #1;
    repeat (40) begin
      send(rnd_val(), rnd_val(), rnd_val(), rnd_val(), rnd_val(),
           longint'($urandom_range(0, 4)), longint'($urandom_range(0, 40)));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
